// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan test controller.
package scan_pkg;

    // Number of scan flops driven when the top is not overridden.
    localparam int CHAIN_LEN_DEFAULT = 5;

    // Sequencer states. Encodings are fixed so waveforms stay comparable
    // across revisions.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_IN  = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_SHIFT_OUT = 3'd3,
        ST_DONE      = 3'd4
    } scan_state_t;

endpackage

// File: rtl/scan_bit_cnt.sv
// Loadable up-counter with a terminal-count flag. It saturates at TERMINAL
// instead of wrapping, so a state can never see the count roll over.
module scan_bit_cnt #(
    parameter int WIDTH    = 3,
    parameter int TERMINAL = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;
    logic             w_tc;

    assign w_tc    = (r_count == WIDTH'(TERMINAL));
    assign o_count = r_count;
    assign o_tc    = w_tc;

    // Counter register: reset, then load, then saturating increment.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !w_tc) begin
            r_count <= r_count + WIDTH'(1'b1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: shifts a pattern into a scan chain MSB first,
// optionally pulses one capture cycle, unloads the chain and compares the
// unloaded response against the expected value.
module scan_test_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input  logic                 CK,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 capture_en,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 scan_out,
    output logic                 scan_enable,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured
);

    localparam int CW = $clog2(CHAIN_LEN + 1);

    scan_state_t          r_state;
    scan_state_t          w_state_next;
    logic [CHAIN_LEN-1:0] r_pattern;
    logic [CHAIN_LEN-1:0] r_expected;
    logic                 r_cap;
    logic [CHAIN_LEN-1:0] r_shreg;
    logic [CHAIN_LEN-1:0] w_shreg_next;
    logic [CHAIN_LEN-1:0] r_captured;
    logic                 r_pass;
    logic                 w_match;
    logic                 w_pat_bit;
    logic [CW-1:0]        w_count;
    logic                 w_tc;
    logic                 w_cnt_load;
    logic                 w_cnt_en;

    // The counter restarts from zero whenever the state changes and only
    // advances while bits are moving through the chain.
    assign w_cnt_load = (w_state_next != r_state);
    assign w_cnt_en   = (r_state == ST_SHIFT_IN) || (r_state == ST_SHIFT_OUT);

    scan_bit_cnt #(
        .WIDTH    (CW),
        .TERMINAL (CHAIN_LEN - 1)
    ) u_bit_cnt (
        .i_clk      (CK),
        .i_rst_n    (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val ({CW{1'b0}}),
        .i_en       (w_cnt_en),
        .o_count    (w_count),
        .o_tc       (w_tc)
    );

    // Unload shift: the bit returned from the chain's last flop enters at
    // bit 0, so the first bit sampled ends up in the MSB.
    generate
        if (CHAIN_LEN == 1) begin : g_shreg_one
            assign w_shreg_next = scan_out;
        end else begin : g_shreg_many
            assign w_shreg_next = {r_shreg[CHAIN_LEN-2:0], scan_out};
        end
    endgenerate

    assign w_match = (r_shreg == r_expected);

    // Next-state logic of the sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SHIFT_IN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT_IN: begin
                if (w_tc) begin
                    if (r_cap) begin
                        w_state_next = ST_CAPTURE;
                    end else begin
                        w_state_next = ST_SHIFT_OUT;
                    end
                end else begin
                    w_state_next = ST_SHIFT_IN;
                end
            end
            ST_CAPTURE:   w_state_next = ST_SHIFT_OUT;
            ST_SHIFT_OUT: begin
                if (w_tc) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SHIFT_OUT;
                end
            end
            ST_DONE:      w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    // Pick the pattern bit for the current shift-in slot (MSB goes first).
    always_comb begin
        w_pat_bit = 1'b0;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (w_count == CW'(CHAIN_LEN - 1 - i)) begin
                w_pat_bit = r_pattern[i];
            end else begin
                w_pat_bit = w_pat_bit;
            end
        end
    end

    // Chain controls and status decoded purely from registered state and
    // count; the DONE cycle presents the live unload result, afterwards the
    // held copy is shown.
    always_comb begin
        scan_enable = 1'b0;
        scan_in     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        captured    = r_captured;
        pass        = r_pass;
        case (r_state)
            ST_SHIFT_IN: begin
                scan_enable = 1'b1;
                scan_in     = w_pat_bit;
                busy        = 1'b1;
            end
            ST_CAPTURE: begin
                busy        = 1'b1;
            end
            ST_SHIFT_OUT: begin
                scan_enable = 1'b1;
                busy        = 1'b1;
            end
            ST_DONE: begin
                done        = 1'b1;
                captured    = r_shreg;
                pass        = w_match;
            end
            default: begin
                scan_enable = 1'b0;
            end
        endcase
    end

    // State register, request latching and unload shift register.
    always_ff @(posedge CK) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pattern  <= {CHAIN_LEN{1'b0}};
            r_expected <= {CHAIN_LEN{1'b0}};
            r_cap      <= 1'b0;
            r_shreg    <= {CHAIN_LEN{1'b0}};
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && start) begin
                r_pattern  <= pattern;
                r_expected <= expected;
                r_cap      <= capture_en;
            end else begin
                r_pattern  <= r_pattern;
                r_expected <= r_expected;
                r_cap      <= r_cap;
            end
            if (r_state == ST_SHIFT_OUT) begin
                r_shreg <= w_shreg_next;
            end else begin
                r_shreg <= r_shreg;
            end
        end
    end

    // Hold the result of the last completed sequence until the next DONE.
    always_ff @(posedge CK) begin
        if (!rst_n) begin
            r_captured <= {CHAIN_LEN{1'b0}};
            r_pass     <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_captured <= r_shreg;
            r_pass     <= w_match;
        end else begin
            r_captured <= r_captured;
            r_pass     <= r_pass;
        end
    end

endmodule
